// File: rtl/bram_pkg.sv
// Shared types for the bramsd read-side streaming logic: RAM read latency,
// streamer FSM states and the in-flight read tag.
package bram_pkg;

    localparam int BRAMSD_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Count-based circular buffer holding {last, data} beats between the RAM read
// pipeline and the output stream. Head is read straight from registered storage.
module rd_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    // Push and pop in the same cycle leave count unchanged, even at full/empty.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_rd_stream.sv
// Streams len consecutive words from a bramsd read port starting at base, hiding
// the RAM read latency and consumer backpressure behind a credit-limited FIFO.
module bram_rd_stream
    import bram_pkg::*;
#(
    parameter int ADDR_  = 8,
    parameter int DATA_  = 8,
    parameter int RD_LAT = BRAMSD_RD_LAT,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             start,
    input  logic [ADDR_-1:0] base,
    input  logic [ADDR_:0]   len,
    output logic             busy,
    output logic             done,
    output logic [ADDR_-1:0] raddr,
    input  logic [DATA_-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DATA_-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    rd_state_t        state;
    logic [ADDR_:0]   remaining;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_used;
    logic             issue;
    logic             last_issue;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [DATA_:0]   fifo_head;
    rd_tag_t          tag_pipe [RD_LAT];

    // A read is only issued when a FIFO slot is guaranteed for its data.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign issue       = (state == RUN) && (credit_used < (CW+1)'(DEPTH));
    assign last_issue  = issue && (remaining == (ADDR_+1)'(1));

    assign push      = tag_pipe[RD_LAT-1].valid;
    assign pop       = m_valid && m_ready;
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_head[DATA_-1:0];
    assign m_last    = fifo_head[DATA_];
    assign dbg_state = state;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            raddr     <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        raddr     <= base;
                        remaining <= len;
                        busy      <= 1'b1;
                        if (len != '0) begin
                            state <= RUN;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        raddr     <= raddr + ADDR_'(1);
                        remaining <= remaining - (ADDR_+1)'(1);
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tags travel alongside the RAM pipeline so rdata is pushed exactly when valid.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            inflight <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '{valid: 1'b0, last: 1'b0};
            end
        end else begin
            tag_pipe[0] <= '{valid: issue, last: last_issue};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    rd_skid_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_ + 1)
    ) u_fifo (
        .clk       (clk),
        .aclr      (aclr),
        .push      (push),
        .push_data ({tag_pipe[RD_LAT-1].last, rdata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_bram_rd_stream.sv
// Bench for bram_rd_stream paired with a two-stage bramsd read model (mem[i]=i^A5).
module tb_bram_rd_stream;
    import bram_pkg::*;

    logic       clk = 1'b0;
    logic       aclr;
    logic       start;
    logic [7:0] base;
    logic [8:0] len;
    logic       busy;
    logic       done;
    logic [7:0] raddr;
    logic [7:0] rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [1:0] dbg_state;

    // clock / reset
    always #5 clk = ~clk;

    bram_rd_stream #(.ADDR_(8), .DATA_(8), .RD_LAT(2), .DEPTH(4)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .dbg_state (dbg_state)
    );

    // bramsd read port: address register then output register
    logic [7:0] ram_mem [256];
    logic [7:0] ram_a_q;
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i) ^ 8'hA5;
    end
    always @(posedge clk) begin
        ram_a_q <= raddr;
        rdata   <= ram_mem[ram_a_q];
    end

    // scoreboard
    logic [8:0] exp_q[$];
    logic [7:0] raddr_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         duty;
        int         exp_first;
        int         exp_done;
        bit         chk_wrap;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] model_word(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_expected(input logic [7:0] b, input logic [8:0] l);
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back({(i == int'(l) - 1), model_word(b + 8'(i))});
        end
    endtask

    // driver: one transfer; c counts cycles after the cycle start is sampled in
    task automatic run_xfer(input logic [7:0] b, input logic [8:0] l, input int duty,
                            output int first_lat, output int done_lat, output int beats,
                            output int lasts, output int busy_cyc);
        logic       prev_stall;
        logic [8:0] prev_d;
        logic [8:0] exp;
        @(negedge clk);
        start = 1'b1;
        base  = b;
        len   = l;
        push_expected(b, l);
        raddr_q.delete();
        first_lat  = -1;
        done_lat   = -1;
        beats      = 0;
        lasts      = 0;
        busy_cyc   = 0;
        prev_stall = 1'b0;
        prev_d     = '0;
        for (int c = 1; c <= 2000 && done_lat < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_hold", 32'({m_last, m_data}), 32'(prev_d));
            end
            m_ready = ($urandom_range(0, 99) < duty);
            raddr_q.push_back(raddr);
            if (busy) busy_cyc++;
            if (m_valid && first_lat < 0) first_lat = c;
            if (m_valid && m_ready) begin
                beats++;
                if (m_last) lasts++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got %0h expected none", {m_last, m_data});
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", 32'({m_last, m_data}), 32'(exp));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = {m_last, m_data};
            if (done) begin
                done_lat = c;
                check("fin_state", 32'(dbg_state), 32'(FIN));
            end
        end
        if (done_lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
        end
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_valid", 32'(m_valid), 32'd0);
    endtask

    int first_lat, done_lat, beats, lasts, busy_cyc, hs;
    logic [8:0] exp_w;
    logic [7:0] wrap_exp [4];

    initial begin
        aclr    = 1'b1;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        m_ready = 1'b1;

        vecs[0] = '{base: 8'h10, len: 9'd8,   duty: 100, exp_first: 4,  exp_done: 12,  chk_wrap: 1'b0};
        vecs[1] = '{base: 8'hFE, len: 9'd4,   duty: 100, exp_first: 4,  exp_done: 8,   chk_wrap: 1'b1};
        vecs[2] = '{base: 8'h00, len: 9'd0,   duty: 100, exp_first: -1, exp_done: 1,   chk_wrap: 1'b0};
        vecs[3] = '{base: 8'h37, len: 9'd16,  duty: 30,  exp_first: 4,  exp_done: -1,  chk_wrap: 1'b0};
        vecs[4] = '{base: 8'h00, len: 9'd256, duty: 100, exp_first: 4,  exp_done: 260, chk_wrap: 1'b0};
        vecs[5] = '{base: 8'h80, len: 9'd1,   duty: 100, exp_first: 4,  exp_done: 5,   chk_wrap: 1'b0};
        wrap_exp[0] = 8'hFE;
        wrap_exp[1] = 8'hFF;
        wrap_exp[2] = 8'h00;
        wrap_exp[3] = 8'h01;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        aclr = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].duty,
                     first_lat, done_lat, beats, lasts, busy_cyc);
            check($sformatf("v%0d_first", v), 32'(first_lat), 32'(vecs[v].exp_first));
            if (vecs[v].exp_done >= 0)
                check($sformatf("v%0d_done", v), 32'(done_lat), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_beats", v), 32'(beats), 32'(vecs[v].len));
            check($sformatf("v%0d_lasts", v), 32'(lasts), 32'(vecs[v].len != 0));
            check($sformatf("v%0d_busy", v), 32'(busy_cyc), 32'(done_lat));
            if (vecs[v].chk_wrap) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("wrap_raddr%0d", k), 32'(raddr_q[k]), 32'(wrap_exp[k]));
            end
        end

        // reset in the middle of a transfer, then restart
        @(negedge clk);
        start   = 1'b1;
        base    = 8'h00;
        len     = 9'd8;
        m_ready = 1'b1;
        push_expected(8'h00, 9'd8);
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && m_ready) begin
                hs++;
                exp_w = exp_q.pop_front();
                check("pre_rst_beat", 32'({m_last, m_data}), 32'(exp_w));
            end
        end
        check("pre_rst_beats", 32'(hs), 32'd3);
        @(negedge clk);
        aclr = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        check("mid_rst_last", 32'(m_last), 32'd0);
        check("mid_rst_raddr", 32'(raddr), 32'd0);
        exp_q.delete();
        @(negedge clk);
        aclr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", 32'(m_valid), 32'd0);
        end
        run_xfer(8'h40, 9'd2, 100, first_lat, done_lat, beats, lasts, busy_cyc);
        check("restart_first", 32'(first_lat), 32'd4);
        check("restart_done", 32'(done_lat), 32'd6);
        check("restart_beats", 32'(beats), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
